// File: rtl/waveform_pkg.sv
// Shared definitions for the waveform playback and capture blocks:
// flush FSM state encoding and default data/address widths.
package waveform_pkg;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        WRITE_LOW     = 2'd1,
        WRITE_HIGH    = 2'd2,
        WAIT_DEASSERT = 2'd3
    } flush_state_e;

    localparam int unsigned DEF_WORD_WID      = 24;
    localparam int unsigned DEF_RAM_WORD_WID  = 16;
    localparam int unsigned DEF_RAM_WORD_INCR = 2;

endpackage

// File: rtl/bram_capture_buf.sv
// Simple dual-port capture buffer: one write port, one registered read port,
// shaped so synthesis maps it onto block RAM.
module bram_capture_buf #(
    parameter int unsigned DATA_WID = 24,
    parameter int unsigned ADDR_WID = 11,
    parameter int unsigned DEPTH    = 2048
) (
    input  logic                clk,
    input  logic                wr_en_i,
    input  logic [ADDR_WID-1:0] wr_addr_i,
    input  logic [DATA_WID-1:0] wr_data_i,
    input  logic [ADDR_WID-1:0] rd_addr_i,
    output logic [DATA_WID-1:0] rd_data_o
);

    logic [DATA_WID-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/bram_capture.sv
// Captures producer words into a local buffer and flushes them to RAM over the
// 16-bit DMA write port. Define BRAM_CAPTURE_SIGN_EXTEND_EN to sign-extend the high RAM word.
module bram_capture
    import waveform_pkg::*;
#(
    parameter int unsigned WORD_WID      = DEF_WORD_WID,
    parameter int unsigned WORD_AMNT_WID = 11,
    parameter int unsigned WORD_AMNT     = 2047,
    parameter int unsigned RAM_WID       = 32,
    parameter int unsigned RAM_WORD_WID  = DEF_RAM_WORD_WID,
    parameter int unsigned RAM_WORD_INCR = DEF_RAM_WORD_INCR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WORD_WID-1:0]     word,
    input  logic                    word_valid,
    output logic                    word_ack,
    input  logic                    word_rst,
    output logic                    buf_full,
    input  logic                    flush_start,
    input  logic [RAM_WID-1:0]      start_addr,
    output logic                    flush_finished,
    output logic [RAM_WID-1:0]      ram_dma_addr,
    output logic [RAM_WORD_WID-1:0] ram_word,
    output logic                    ram_write,
    input  logic                    ram_done
);

    localparam int unsigned LEN_WID = WORD_AMNT_WID + 1;
    localparam int unsigned HI_WID  = WORD_WID - RAM_WORD_WID;
    localparam int unsigned EXT_WID = RAM_WORD_WID - HI_WID;
    localparam logic [LEN_WID-1:0]       FULL_LEN  = LEN_WID'(WORD_AMNT + 1);
    localparam logic [WORD_AMNT_WID-1:0] LAST_IDX  = WORD_AMNT_WID'(WORD_AMNT);
    localparam logic [RAM_WID-1:0]       ADDR_INCR = RAM_WID'(RAM_WORD_INCR);

    flush_state_e              state_q;
    logic [WORD_AMNT_WID-1:0]  cap_cntr_q;
    logic                      buf_full_q;
    logic                      word_ack_q;
    logic                      flush_finished_q;
    logic [RAM_WID-1:0]        ram_addr_q;
    logic [RAM_WORD_WID-1:0]   ram_word_q;
    logic                      ram_write_q;
    logic [WORD_AMNT_WID-1:0]  rd_idx_q;
    logic [WORD_AMNT_WID-1:0]  rd_idx_d;
    logic [LEN_WID-1:0]        len_q;
    logic [LEN_WID-1:0]        len_d;
    logic                      accept;
    logic                      rd_last;
    logic [WORD_WID-1:0]       rd_data;
    logic [RAM_WORD_WID-1:0]   hi_word;

    always_comb begin
        len_d   = buf_full_q ? FULL_LEN : {1'b0, cap_cntr_q};
        accept  = (state_q == IDLE) && word_valid && !word_ack_q && !buf_full_q
                  && !flush_start && !word_rst;
        rd_last = ({1'b0, rd_idx_q} == (len_q - 1'b1));
        // Read address is the next-cycle index so the registered read lands in time.
        rd_idx_d = rd_idx_q;
        if (state_q == IDLE && flush_start) begin
            rd_idx_d = '0;
        end else if (state_q == WRITE_HIGH && ram_write_q && ram_done) begin
            rd_idx_d = rd_idx_q + 1'b1;
        end
    end

`ifdef BRAM_CAPTURE_SIGN_EXTEND_EN
    assign hi_word = {{EXT_WID{rd_data[WORD_WID-1]}}, rd_data[WORD_WID-1:RAM_WORD_WID]};
`else
    assign hi_word = {{EXT_WID{1'b0}}, rd_data[WORD_WID-1:RAM_WORD_WID]};
`endif

    bram_capture_buf #(
        .DATA_WID (WORD_WID),
        .ADDR_WID (WORD_AMNT_WID),
        .DEPTH    (WORD_AMNT + 1)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (accept),
        .wr_addr_i (cap_cntr_q),
        .wr_data_i (word),
        .rd_addr_i (rd_idx_d),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            cap_cntr_q       <= '0;
            buf_full_q       <= 1'b0;
            word_ack_q       <= 1'b0;
            flush_finished_q <= 1'b0;
            ram_addr_q       <= '0;
            ram_word_q       <= '0;
            ram_write_q      <= 1'b0;
            rd_idx_q         <= '0;
            len_q            <= '0;
        end else begin
            rd_idx_q <= rd_idx_d;

            if (state_q == IDLE && word_rst) begin
                cap_cntr_q <= '0;
                buf_full_q <= 1'b0;
                word_ack_q <= 1'b0;
            end else if (accept) begin
                word_ack_q <= 1'b1;
                if (cap_cntr_q == LAST_IDX) begin
                    buf_full_q <= 1'b1;
                    cap_cntr_q <= '0;
                end else begin
                    cap_cntr_q <= cap_cntr_q + 1'b1;
                end
            end else if (!word_valid && word_ack_q) begin
                word_ack_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (flush_start) begin
                        ram_addr_q <= start_addr;
                        len_q      <= len_d;
                        state_q    <= (len_d == '0) ? WAIT_DEASSERT : WRITE_LOW;
                    end
                end
                WRITE_LOW: begin
                    if (!ram_write_q) begin
                        ram_word_q  <= rd_data[RAM_WORD_WID-1:0];
                        ram_write_q <= 1'b1;
                    end else if (ram_done) begin
                        ram_write_q <= 1'b0;
                        ram_addr_q  <= ram_addr_q + ADDR_INCR;
                        state_q     <= WRITE_HIGH;
                    end
                end
                WRITE_HIGH: begin
                    if (!ram_write_q) begin
                        ram_word_q  <= hi_word;
                        ram_write_q <= 1'b1;
                    end else if (ram_done) begin
                        ram_write_q <= 1'b0;
                        ram_addr_q  <= ram_addr_q + ADDR_INCR;
                        if (rd_last) begin
                            state_q    <= WAIT_DEASSERT;
                            cap_cntr_q <= '0;
                            buf_full_q <= 1'b0;
                        end else begin
                            state_q <= WRITE_LOW;
                        end
                    end
                end
                WAIT_DEASSERT: begin
                    if (flush_start) begin
                        flush_finished_q <= 1'b1;
                    end else begin
                        flush_finished_q <= 1'b0;
                        state_q          <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign word_ack       = word_ack_q;
    assign buf_full       = buf_full_q;
    assign flush_finished = flush_finished_q;
    assign ram_dma_addr   = ram_addr_q;
    assign ram_word       = ram_word_q;
    assign ram_write      = ram_write_q;

endmodule

// File: tb/tb_bram_capture.sv
// Scoreboard bench for bram_capture with a 4-word buffer: expected DMA writes are
// queued when a flush is requested and checked by an independent RAM-port monitor.
module tb_bram_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] word;
    logic        word_valid;
    logic        word_ack;
    logic        word_rst;
    logic        buf_full;
    logic        flush_start;
    logic [31:0] start_addr;
    logic        flush_finished;
    logic [31:0] ram_dma_addr;
    logic [15:0] ram_word;
    logic        ram_write;
    logic        ram_done;

    always #5 clk = ~clk;

    bram_capture #(
        .WORD_WID      (24),
        .WORD_AMNT_WID (2),
        .WORD_AMNT     (3),
        .RAM_WID       (32),
        .RAM_WORD_WID  (16),
        .RAM_WORD_INCR (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .word           (word),
        .word_valid     (word_valid),
        .word_ack       (word_ack),
        .word_rst       (word_rst),
        .buf_full       (buf_full),
        .flush_start    (flush_start),
        .start_addr     (start_addr),
        .flush_finished (flush_finished),
        .ram_dma_addr   (ram_dma_addr),
        .ram_word       (ram_word),
        .ram_write      (ram_write),
        .ram_done       (ram_done)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } exp_t;

    typedef struct packed {
        logic [23:0] w;
        logic [15:0] lo;
        logic [15:0] hz;
        logic [15:0] hs;
    } vec_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          writes = 0;
    int          done_delay = 0;
    logic [31:0] last_addr = '0;

    // word, low RAM word, high word zero-extended, high word sign-extended
    vec_t full_vec [4] = '{
        '{24'h123456, 16'h3456, 16'h0012, 16'h0012},
        '{24'hABCDEF, 16'hCDEF, 16'h00AB, 16'hFFAB},
        '{24'h000001, 16'h0001, 16'h0000, 16'h0000},
        '{24'h7FFFFF, 16'hFFFF, 16'h007F, 16'h007F}
    };
    vec_t part_vec [2] = '{
        '{24'h0A0B0C, 16'h0B0C, 16'h000A, 16'h000A},
        '{24'hFEDCBA, 16'hDCBA, 16'h00FE, 16'hFFFE}
    };
    vec_t sign_vec = '{24'h800001, 16'h0001, 16'h0080, 16'hFF80};
    vec_t beef_vec = '{24'h00BEEF, 16'hBEEF, 16'h0000, 16'h0000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] hi_of(input vec_t v);
`ifdef BRAM_CAPTURE_SIGN_EXTEND_EN
        return v.hs;
`else
        return v.hz;
`endif
    endfunction

    task automatic push_word(input logic [31:0] base, input int idx, input vec_t v);
        sb.push_back('{base + 32'(4 * idx), v.lo});
        sb.push_back('{base + 32'(4 * idx + 2), hi_of(v)});
    endtask

    task automatic capture(input logic [23:0] w, input logic expect_ack);
        logic got;
        got = 1'b0;
        word = w;
        word_valid = 1'b1;
        for (int c = 0; c < 8 && !got; c++) begin
            @(posedge clk); #1;
            if (word_ack) got = 1'b1;
        end
        check("word_ack", {31'b0, got}, {31'b0, expect_ack});
        word_valid = 1'b0;
        for (int c = 0; c < 4 && word_ack; c++) begin
            @(posedge clk); #1;
        end
        check("word_ack_release", {31'b0, word_ack}, 32'd0);
    endtask

    task automatic flush_run(input logic [31:0] a);
        start_addr = a;
        flush_start = 1'b1;
        for (int c = 0; c < 400 && !flush_finished; c++) begin
            @(posedge clk); #1;
        end
        check("flush_finished", {31'b0, flush_finished}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("flush_finished_held", {31'b0, flush_finished}, 32'd1);
        flush_start = 1'b0;
        @(posedge clk); #1;
        check("flush_finished_drop", {31'b0, flush_finished}, 32'd0);
        check("buf_full_after_flush", {31'b0, buf_full}, 32'd0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    // RAM model: acknowledges each write after done_delay extra cycles.
    initial begin
        int cnt;
        cnt = 0;
        ram_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ram_write && !ram_done) begin
                if (cnt >= done_delay) begin
                    ram_done = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                ram_done = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: new write pulses pop the scoreboard; held pulses must not change.
    initial begin
        logic        prev;
        logic [31:0] held_addr;
        logic [15:0] held_word;
        exp_t        e;
        prev = 1'b0;
        held_addr = '0;
        held_word = '0;
        forever begin
            @(negedge clk);
            if (ram_write) begin
                if (!prev) begin
                    writes++;
                    last_addr = ram_dma_addr;
                    held_addr = ram_dma_addr;
                    held_word = ram_word;
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                                 ram_dma_addr, ram_word);
                    end else begin
                        e = sb.pop_front();
                        check("ram_dma_addr", ram_dma_addr, e.addr);
                        check("ram_word", {16'b0, ram_word}, {16'b0, e.data});
                    end
                end else begin
                    check("addr_stable", ram_dma_addr, held_addr);
                    check("word_stable", {16'b0, ram_word}, {16'b0, held_word});
                end
            end
            prev = ram_write;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst = 1'b1;
        word = '0;
        word_valid = 1'b0;
        word_rst = 1'b0;
        flush_start = 1'b0;
        start_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_word_ack", {31'b0, word_ack}, 32'd0);
        check("rst_buf_full", {31'b0, buf_full}, 32'd0);
        check("rst_flush_finished", {31'b0, flush_finished}, 32'd0);
        check("rst_ram_write", {31'b0, ram_write}, 32'd0);
        check("rst_ram_dma_addr", ram_dma_addr, 32'd0);
        check("rst_ram_word", {16'b0, ram_word}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full buffer, then a stalled fifth request
        for (int i = 0; i < 4; i++) begin
            capture(full_vec[i].w, 1'b1);
            check("buf_full_fill", {31'b0, buf_full}, (i == 3) ? 32'd1 : 32'd0);
        end
        capture(24'h555555, 1'b0);
        for (int i = 0; i < 4; i++) push_word(32'h1000, i, full_vec[i]);
        w0 = writes;
        flush_run(32'h1000);
        check("full_write_count", 32'(writes - w0), 32'd8);
        check("full_last_addr", last_addr, 32'h100E);

        // Partial flush
        for (int i = 0; i < 2; i++) capture(part_vec[i].w, 1'b1);
        for (int i = 0; i < 2; i++) push_word(32'h2000, i, part_vec[i]);
        w0 = writes;
        flush_run(32'h2000);
        check("partial_write_count", 32'(writes - w0), 32'd4);
        check("partial_last_addr", last_addr, 32'h2006);

        // Counter restarted at zero: full exactly on the fourth word; word_rst then empties it
        for (int i = 0; i < 4; i++) begin
            capture(full_vec[i].w, 1'b1);
            check("refill_buf_full", {31'b0, buf_full}, (i == 3) ? 32'd1 : 32'd0);
        end
        word_rst = 1'b1;
        @(posedge clk); #1;
        word_rst = 1'b0;
        check("word_rst_buf_full", {31'b0, buf_full}, 32'd0);

        // Empty flush
        w0 = writes;
        start_addr = 32'h6000;
        flush_start = 1'b1;
        @(posedge clk); #1;
        check("empty_finished_early", {31'b0, flush_finished}, 32'd0);
        @(posedge clk); #1;
        check("empty_finished", {31'b0, flush_finished}, 32'd1);
        flush_start = 1'b0;
        @(posedge clk); #1;
        check("empty_finished_drop", {31'b0, flush_finished}, 32'd0);
        check("empty_write_count", 32'(writes - w0), 32'd0);

        // Slow RAM and high-word extension
        done_delay = 5;
        capture(sign_vec.w, 1'b1);
        push_word(32'h3000, 0, sign_vec);
        flush_run(32'h3000);

        // Reset during the high-word write, then a fresh flush
        for (int i = 0; i < 2; i++) capture(part_vec[i].w, 1'b1);
        sb.push_back('{32'h4000, part_vec[0].lo});
        sb.push_back('{32'h4002, hi_of(part_vec[0])});
        w0 = writes;
        start_addr = 32'h4000;
        flush_start = 1'b1;
        for (int c = 0; c < 100 && (writes - w0) < 2; c++) begin
            @(posedge clk); #1;
        end
        check("reset_reached_high", 32'(writes - w0), 32'd2);
        rst = 1'b1;
        #1;
        check("midrst_ram_write", {31'b0, ram_write}, 32'd0);
        check("midrst_ram_dma_addr", ram_dma_addr, 32'd0);
        check("midrst_ram_word", {16'b0, ram_word}, 32'd0);
        check("midrst_flush_finished", {31'b0, flush_finished}, 32'd0);
        check("midrst_buf_full", {31'b0, buf_full}, 32'd0);
        check("midrst_scoreboard", 32'(sb.size()), 32'd0);
        sb.delete();
        flush_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        capture(beef_vec.w, 1'b1);
        push_word(32'h5000, 0, beef_vec);
        w0 = writes;
        flush_run(32'h5000);
        check("post_reset_write_count", 32'(writes - w0), 32'd2);
        check("post_reset_last_addr", last_addr, 32'h5002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
